// File: rtl/half_pkg.sv
// ---------------------------------------------------------------------------
// half_pkg
// Shared IEEE-754 half-precision helpers for the half_* datapath blocks
// (arg-max, sigmoid and add stages).
// Contents:
//   HALF_EXP_MASK / HALF_MANT_MASK  field masks of an FP16 word
//   argmax_state_e                  scan controller states of half_argmax_v
//   half_is_nan()                   true for exp all-ones with non-zero mantissa
//   half_order_key()                maps an FP16 word to an unsigned total-order key
// ---------------------------------------------------------------------------
package half_pkg;

  localparam logic [15:0] HALF_EXP_MASK  = 16'h7C00;
  localparam logic [15:0] HALF_MANT_MASK = 16'h03FF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } argmax_state_e;

  // A NaN has every exponent bit set and at least one mantissa bit set;
  // infinities (mantissa zero) are ordinary ordered values.
  function automatic logic half_is_nan(input logic [15:0] x);
    return ((x & HALF_EXP_MASK) == HALF_EXP_MASK) &&
           ((x & HALF_MANT_MASK) != 16'h0000);
  endfunction

  // Sign-magnitude to unsigned ordering: negatives are bit-inverted so larger
  // magnitudes sort lower, positives get the sign bit flipped so they sort
  // above every negative. -0 is folded onto +0 first so the two compare equal.
  function automatic logic [15:0] half_order_key(input logic [15:0] x);
    logic [15:0] v;
    v = (x == 16'h8000) ? 16'h0000 : x;
    return v[15] ? ~v : (v ^ 16'h8000);
  endfunction

endpackage

// File: rtl/half_compare_gt.sv
// ---------------------------------------------------------------------------
// half_compare_gt
// Purely combinational FP16 "greater than" comparator, no arithmetic.
// Ports:
//   a        in  16  candidate value
//   b        in  16  reference value
//   a_gt_b   out 1   a is strictly greater than b in FP16 order (-0 == +0)
//   a_is_nan out 1   a is a NaN; a_gt_b is meaningless in that case
// ---------------------------------------------------------------------------
module half_compare_gt
  import half_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        a_gt_b,
  output logic        a_is_nan
);

  assign a_is_nan = half_is_nan(a);
  assign a_gt_b   = half_order_key(a) > half_order_key(b);

endmodule

// File: rtl/half_argmax_v.sv
// ---------------------------------------------------------------------------
// half_argmax_v
// Sequential arg-max over WIDTH FP16 values, one element per clock through a
// single shared comparator. The vector is captured on start so the source may
// change during the scan.
// Ports:
//   clk       in  1          system clock, rising edge
//   rstn      in  1          synchronous active-low reset
//   start     in  1          begin a scan, vector_a sampled this cycle
//   vector_a  in  16[WIDTH]  FP16 inputs, element 0 first
//   done      out 1          one-cycle pulse, results valid from this cycle
//   busy      out 1          scan in progress
//   index     out IDX_W      position of the largest non-NaN element
//   max_val   out 16         raw FP16 bits at index
//   valid     out 1          0 when every element was NaN
// ---------------------------------------------------------------------------
module half_argmax_v
  import half_pkg::*;
#(
  parameter  int WIDTH = 10,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [15:0]      vector_a [WIDTH],
  output logic             done,
  output logic             busy,
  output logic [IDX_W-1:0] index,
  output logic [15:0]      max_val,
  output logic             valid
);

  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(WIDTH - 1);

  argmax_state_e    state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [15:0]      buf_q [WIDTH];
  logic [15:0]      buf_d [WIDTH];
  logic [15:0]      best_val_q, best_val_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             best_valid_q, best_valid_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [15:0]      max_val_q, max_val_d;
  logic             valid_q, valid_d;

  logic [15:0]      cur_val;
  logic             cur_gt_best;
  logic             cur_is_nan;
  logic             take_cur;

  // Element select written as a compare chain so the pointer width never has
  // to match the buffer depth exactly (WIDTH=1 still uses a 1-bit pointer).
  always_comb begin
    cur_val = buf_q[0];
    for (int i = 1; i < WIDTH; i++) begin
      if (ptr_q == IDX_W'(i)) cur_val = buf_q[i];
    end
  end

  half_compare_gt u_cmp (
    .a        (cur_val),
    .b        (best_val_q),
    .a_gt_b   (cur_gt_best),
    .a_is_nan (cur_is_nan)
  );

  // Replace only on strictly greater so the lowest index wins ties; an empty
  // best is always replaced by the first non-NaN element.
  assign take_cur = !cur_is_nan && (!best_valid_q || cur_gt_best);

  // Next-state logic: capture on start in IDLE, fold one element per cycle in
  // SCAN and publish the final result together with the done pulse.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    buf_d        = buf_q;
    best_val_d   = best_val_q;
    best_idx_d   = best_idx_q;
    best_valid_d = best_valid_q;
    done_d       = 1'b0;
    index_d      = index_q;
    max_val_d    = max_val_q;
    valid_d      = valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          buf_d        = vector_a;
          ptr_d        = '0;
          best_valid_d = 1'b0;
          state_d      = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (take_cur) begin
          best_val_d   = cur_val;
          best_idx_d   = ptr_q;
          best_valid_d = 1'b1;
        end
        if (ptr_q == LAST_PTR) begin
          done_d    = 1'b1;
          state_d   = ST_IDLE;
          valid_d   = best_valid_d;
          index_d   = best_valid_d ? best_idx_d : '0;
          max_val_d = best_valid_d ? best_val_d : 16'h0000;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
    endcase
  end

  // State and result registers; reset abandons any scan without a done pulse.
  // The capture buffer needs no reset since it is always loaded before use.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    if (!rstn) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      best_val_q   <= 16'h0000;
      best_idx_q   <= '0;
      best_valid_q <= 1'b0;
      done_q       <= 1'b0;
      index_q      <= '0;
      max_val_q    <= 16'h0000;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      best_val_q   <= best_val_d;
      best_idx_q   <= best_idx_d;
      best_valid_q <= best_valid_d;
      done_q       <= done_d;
      index_q      <= index_d;
      max_val_q    <= max_val_d;
      valid_q      <= valid_d;
    end
  end

  assign done    = done_q;
  assign busy    = (state_q == ST_SCAN);
  assign index   = index_q;
  assign max_val = max_val_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_half_argmax_v.sv
// ---------------------------------------------------------------------------
// tb_half_argmax_v
// Self-checking bench for half_argmax_v with a WIDTH=10 and a WIDTH=1
// instance. Expected results come from a reference model that decodes each
// FP16 word to a real number and picks the first strictly-largest non-NaN.
// ---------------------------------------------------------------------------
module tb_half_argmax_v;

  localparam int W = 10;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [15:0] vector_a [W];
  logic        done;
  logic        busy;
  logic [3:0]  index;
  logic [15:0] max_val;
  logic        valid;

  logic        start1;
  logic [15:0] vector1 [1];
  logic        done1;
  logic        busy1;
  logic [0:0]  index1;
  logic [15:0] maxVal1;
  logic        valid1;

  logic [15:0] vecStim [W];
  logic [15:0] pool [12];
  int          expIdx;
  logic [15:0] expVal;
  logic        expValid;
  int          checkCount;
  int          errorCount;

  half_argmax_v #(.WIDTH(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .vector_a (vector_a),
    .done     (done),
    .busy     (busy),
    .index    (index),
    .max_val  (max_val),
    .valid    (valid)
  );

  half_argmax_v #(.WIDTH(1)) dut1 (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start1),
    .vector_a (vector1),
    .done     (done1),
    .busy     (busy1),
    .index    (index1),
    .max_val  (maxVal1),
    .valid    (valid1)
  );

  // Free-running clock; the bench drives and samples on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic isNanHalf(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'h0);
  endfunction

  // Numeric value of an FP16 word; infinities become a huge finite real.
  function automatic real halfToReal(input logic [15:0] h);
    int  e;
    int  p;
    real r;
    e = int'(h[14:10]);
    if (e == 31) begin
      r = 1.0e300;
    end else begin
      r = real'(int'(h[9:0]));
      if (e == 0) begin
        p = -24;
      end else begin
        r = r + 1024.0;
        p = e - 25;
      end
      for (int i = 0; i < p; i++) r = r * 2.0;
      for (int i = 0; i > p; i--) r = r / 2.0;
    end
    return h[15] ? -r : r;
  endfunction

  // Reference arg-max over vecStim: first element with the largest numeric
  // value wins, NaNs are ignored, and -0.0 equals +0.0 as reals.
  task automatic modelArgmax();
    real bestR;
    real r;
    expValid = 1'b0;
    expIdx   = 0;
    expVal   = 16'h0000;
    bestR    = 0.0;
    for (int i = 0; i < W; i++) begin
      if (!isNanHalf(vecStim[i])) begin
        r = halfToReal(vecStim[i]);
        if (!expValid || r > bestR) begin
          expValid = 1'b1;
          bestR    = r;
          expIdx   = i;
          expVal   = vecStim[i];
        end
      end
    end
  endtask

  function automatic logic [15:0] pickValue();
    if ($urandom_range(0, 2) != 0) return pool[$urandom_range(0, 11)];
    return 16'($urandom);
  endfunction

  // Pulse start with vecStim from the current falling edge, then scramble
  // the input so the bench relies on the DUT's captured copy.
  task automatic applyStimulus();
    vector_a = vecStim;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) vector_a[i] = 16'($urandom);
  endtask

  // Wait (bounded) for done, then compare latency and results to the model.
  task automatic waitDone(input string tag, input int elapsed);
    int cnt;
    cnt = elapsed;
    while (done !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput({tag, "_latency"}, cnt, W);
    checkOutput({tag, "_index"}, 32'(index), expIdx);
    checkOutput({tag, "_maxval"}, 32'(max_val), 32'(expVal));
    checkOutput({tag, "_valid"}, 32'(valid), 32'(expValid));
    checkOutput({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic runScan(input string tag);
    modelArgmax();
    applyStimulus();
    checkOutput({tag, "_busyHigh"}, 32'(busy), 1);
    waitDone(tag, 0);
  endtask

  task automatic runScan1(input string tag, input logic [15:0] v);
    int cnt;
    vector1[0] = v;
    start1     = 1'b1;
    @(negedge clk);
    start1     = 1'b0;
    vector1[0] = 16'($urandom);
    cnt = 0;
    while (done1 !== 1'b1 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput({tag, "_latency"}, cnt, 1);
    checkOutput({tag, "_index"}, 32'(index1), 0);
    checkOutput({tag, "_maxval"}, 32'(maxVal1), isNanHalf(v) ? 0 : 32'(v));
    checkOutput({tag, "_valid"}, 32'(valid1), isNanHalf(v) ? 0 : 1);
  endtask

  initial begin
    int doneCnt;
    pool = '{16'h7E00, 16'h7C00, 16'hFC00, 16'h0000, 16'h8000, 16'h3C00,
             16'hBC00, 16'h0001, 16'h8001, 16'h7C01, 16'hFE00, 16'h4000};
    checkCount = 0;
    errorCount = 0;
    rstn   = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    for (int i = 0; i < W; i++) vector_a[i] = 16'h0000;
    vector1[0] = 16'h0000;
    repeat (3) @(negedge clk);

    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_index", 32'(index), 0);
    checkOutput("rst_maxval", 32'(max_val), 0);
    checkOutput("rst_valid", 32'(valid), 0);
    checkOutput("rst_busy1", 32'(busy1), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < W; i++) vecStim[i] = 16'h3800;
    vecStim[1] = 16'h3C00;
    vecStim[2] = 16'h4000;
    runScan("basic");
    checkOutput("basic_idxConst", 32'(index), 2);

    for (int i = 0; i < W; i++) vecStim[i] = 16'h3C00;
    vecStim[3] = 16'h4000;
    vecStim[7] = 16'h4000;
    runScan("tie");
    checkOutput("tie_idxConst", 32'(index), 3);

    for (int i = 0; i < W; i++) vecStim[i] = 16'hBC00;
    vecStim[5] = 16'h8000;
    runScan("negzero");
    checkOutput("negzero_valConst", 32'(max_val), 32'h8000);

    for (int i = 0; i < W; i++) vecStim[i] = 16'h3C00;
    vecStim[0] = 16'h7E00;
    vecStim[4] = 16'h7C00;
    runScan("inf");
    checkOutput("inf_idxConst", 32'(index), 4);

    for (int i = 0; i < W; i++) vecStim[i] = 16'h7E00;
    runScan("allnan");
    checkOutput("allnan_validConst", 32'(valid), 0);

    for (int i = 0; i < W; i++) vecStim[i] = 16'h0000;
    vecStim[6] = 16'h8000;
    vecStim[2] = 16'h8001;
    runScan("zeros");

    // Start pulsed mid-scan must be ignored, giving exactly one done
    for (int i = 0; i < W; i++) vecStim[i] = pickValue();
    modelArgmax();
    applyStimulus();
    repeat (3) @(negedge clk);
    for (int i = 0; i < W; i++) vector_a[i] = 16'h7BFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("midstart", 4);
    doneCnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) doneCnt++;
    end
    checkOutput("midstart_oneDone", doneCnt, 0);
    checkOutput("midstart_idle", 32'(busy), 0);

    // Reset in the middle of a scan: no done, outputs cleared
    for (int i = 0; i < W; i++) vecStim[i] = pickValue();
    vecStim[1] = 16'h4000;
    applyStimulus();
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checkOutput("midrst_index", 32'(index), 0);
    checkOutput("midrst_maxval", 32'(max_val), 0);
    checkOutput("midrst_valid", 32'(valid), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    doneCnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) doneCnt++;
    end
    checkOutput("midrst_noDone", doneCnt, 0);

    // Reset wins over start in the same cycle
    rstn  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    rstn  = 1'b1;
    start = 1'b0;
    checkOutput("rstWins_busy", 32'(busy), 0);

    // Back-to-back scans: next start issued in the done cycle
    for (int i = 0; i < W; i++) vecStim[i] = pickValue();
    runScan("b2bFirst");
    for (int i = 0; i < W; i++) vecStim[i] = pickValue();
    runScan("b2bSecond");
    @(negedge clk);
    checkOutput("b2b_donePulse", 32'(done), 0);

    // Randomized vectors with a bias toward special encodings
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < W; i++) vecStim[i] = pickValue();
      runScan("rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Single-element instance
    runScan1("w1_neg2", 16'hC000);
    runScan1("w1_nan", 16'h7E00);
    for (int n = 0; n < 5; n++) runScan1("w1_rand", pickValue());

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
